// File: rtl/game_timer_core_if.sv
// Command/status bundle between the keypad decoder, the game clock core and the
// display/LED/buzzer drivers. The master drives commands; the slave (core) drives status.
interface game_timer_core_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned TIME_W      = 10
);
  localparam int unsigned AW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;

  // Commands: single-cycle pulses except mode_sel, which is a level
  logic                          mode_sel;
  logic                          new_game;
  logic                          start;
  logic                          pass;
  logic                          pause;
  logic [NUM_PLAYERS-1:0]        resign;

  // Status
  logic [NUM_PLAYERS*TIME_W-1:0] times;
  logic [AW-1:0]                 active;
  logic [1:0]                    state;
  logic [NUM_PLAYERS-1:0]        warn;
  logic [NUM_PLAYERS-1:0]        timeout;
  logic                          game_over;
  logic [AW-1:0]                 loser;

  modport master (
    output mode_sel, new_game, start, pass, pause, resign,
    input  times, active, state, warn, timeout, game_over, loser
  );

  modport slave (
    input  mode_sel, new_game, start, pass, pause, resign,
    output times, active, state, warn, timeout, game_over, loser
  );
endinterface

// File: rtl/game_timer_core.sv
// N-player game clock core: per-player countdown in tenths of a second, Fischer increment
// on pass, pause/resume, resign, timeout detection and a game-over state.
module game_timer_core #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned TIME_W      = 10,
  parameter int unsigned TICK_DIV    = 5000000,
  parameter int unsigned INIT_TIME_A = 100,
  parameter int unsigned INIT_TIME_B = 300,
  parameter int unsigned INC_TIME    = 0,
  parameter int unsigned WARN_THRESH = 50
) (
  input  logic               clk,
  input  logic               clr,
  game_timer_core_if.slave   bus_io
);

  localparam int unsigned AW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TIME_W-1:0] TimeA    = TIME_W'(INIT_TIME_A);
  localparam logic [TIME_W-1:0] TimeB    = TIME_W'(INIT_TIME_B);
  localparam logic [TIME_W-1:0] WarnLim  = TIME_W'(WARN_THRESH);
  localparam logic [TIME_W:0]   IncTime  = (TIME_W+1)'(INC_TIME);
  localparam logic [PW-1:0]     PresLast = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0]     LastIdx  = AW'(NUM_PLAYERS - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StOver  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [TIME_W-1:0]      times_q [NUM_PLAYERS];
  logic [TIME_W-1:0]      times_d [NUM_PLAYERS];
  logic [AW-1:0]          active_q, active_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [NUM_PLAYERS-1:0] timeout_q, timeout_d;
  logic [AW-1:0]          loser_q, loser_d;
  logic                   game_over_q;

  // Shared decode of the current cycle
  logic              tick;
  logic [TIME_W-1:0] act_time;
  logic              act_expire;
  logic              resign_any;
  logic [AW-1:0]     resign_idx;
  logic [TIME_W-1:0] init_time;
  logic [TIME_W-1:0] dec_time;
  logic [TIME_W:0]   inc_sum;
  logic [TIME_W-1:0] inc_time;
  logic [AW-1:0]     next_active;

  assign tick       = (presc_q == PresLast);
  assign act_time   = times_q[active_q];
  // Only a tick that takes the running clock from 1 to 0 flags the player
  assign act_expire = tick && (act_time == TIME_W'(1));
  assign resign_any = |bus_io.resign;
  assign init_time  = bus_io.mode_sel ? TimeB : TimeA;
  assign dec_time   = (tick && (act_time != '0)) ? act_time - TIME_W'(1) : act_time;
  assign inc_sum    = {1'b0, dec_time} + IncTime;
  assign inc_time   = inc_sum[TIME_W] ? '1 : inc_sum[TIME_W-1:0];
  assign next_active = (active_q == LastIdx) ? '0 : active_q + AW'(1);

  // Lowest set resign bit identifies the loser
  always_comb begin
    resign_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (bus_io.resign[i]) resign_idx = AW'(i);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; new_game overrides every state
  always_comb begin
    state_d = state_q;
    if (bus_io.new_game) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) state_d = StRun;
        end
        StRun: begin
          if (resign_any)        state_d = StOver;
          else if (act_expire)   state_d = StOver;
          else if (bus_io.pass)  state_d = StRun;
          else if (bus_io.pause) state_d = StPause;
        end
        StPause: begin
          if (resign_any)        state_d = StOver;
          else if (bus_io.pause) state_d = StRun;
        end
        StOver: begin
          state_d = StOver;
        end
      endcase
    end
  end

  // Datapath next state: times, active player, prescaler, flags
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) times_d[i] = times_q[i];
    active_d  = active_q;
    presc_d   = presc_q;
    timeout_d = timeout_q;
    loser_d   = loser_q;
    if (bus_io.new_game) begin
      for (int i = 0; i < NUM_PLAYERS; i++) times_d[i] = init_time;
      active_d  = '0;
      presc_d   = '0;
      timeout_d = '0;
      loser_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          for (int i = 0; i < NUM_PLAYERS; i++) times_d[i] = init_time;
          presc_d = '0;
          if (bus_io.start) active_d = '0;
        end
        StRun: begin
          if (resign_any) begin
            loser_d = resign_idx;
          end else if (act_expire) begin
            // Flag wins over a same-cycle pass: no increment, no turn change
            times_d[active_q]   = '0;
            timeout_d[active_q] = 1'b1;
            loser_d             = active_q;
            presc_d             = '0;
          end else begin
            presc_d           = tick ? '0 : presc_q + PW'(1);
            times_d[active_q] = dec_time;
            if (bus_io.pass) begin
              times_d[active_q] = inc_time;
              active_d          = next_active;
              presc_d           = '0;
            end
          end
        end
        StPause: begin
          // Prescaler frozen so a resume continues the interrupted tenth
          if (resign_any) loser_d = resign_idx;
        end
        StOver: begin
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_PLAYERS; i++) times_q[i] <= TimeA;
      active_q    <= '0;
      presc_q     <= '0;
      timeout_q   <= '0;
      loser_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) times_q[i] <= times_d[i];
      active_q    <= active_d;
      presc_q     <= presc_d;
      timeout_q   <= timeout_d;
      loser_q     <= loser_d;
      game_over_q <= (state_d == StOver);
    end
  end

  // Outputs: registered values, plus warn decoded from the registered times
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      bus_io.times[i*TIME_W +: TIME_W] = times_q[i];
      bus_io.warn[i] = (times_q[i] != '0) && (times_q[i] <= WarnLim);
    end
    bus_io.active    = active_q;
    bus_io.state     = state_q;
    bus_io.timeout   = timeout_q;
    bus_io.game_over = game_over_q;
    bus_io.loser     = loser_q;
  end

endmodule

// File: tb/tb_game_timer_core.sv
module tb_game_timer_core;
  localparam int NP   = 3;
  localparam int TW   = 10;
  localparam int TDIV = 4;
  localparam int TA   = 100;
  localparam int TB   = 300;
  localparam int INC  = 5;
  localparam int WTH  = 50;
  localparam int TMAX = 1023;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  game_timer_core_if #(.NUM_PLAYERS(NP), .TIME_W(TW)) bus ();
  game_timer_core_if #(.NUM_PLAYERS(NP), .TIME_W(TW)) sbus ();

  game_timer_core #(
    .NUM_PLAYERS(NP), .TIME_W(TW), .TICK_DIV(TDIV), .INIT_TIME_A(TA),
    .INIT_TIME_B(TB), .INC_TIME(INC), .WARN_THRESH(WTH)
  ) u_dut (
    .clk(clk), .clr(clr), .bus_io(bus)
  );

  // Second instance starting at the counter ceiling for the saturation case
  game_timer_core #(
    .NUM_PLAYERS(NP), .TIME_W(TW), .TICK_DIV(TDIV), .INIT_TIME_A(TMAX),
    .INIT_TIME_B(TB), .INC_TIME(INC), .WARN_THRESH(WTH)
  ) u_sat (
    .clk(clk), .clr(clr), .bus_io(sbus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: game rules in plain integers (state 0 idle,1 run,2 pause,3 over)
  int m_t [NP];
  int m_act, m_state, m_pre, m_to, m_los;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_t[i]) m_t[i] = TA;
    m_act = 0; m_state = 0; m_pre = 0; m_to = 0; m_los = 0;
  endtask

  task automatic model_step(input bit ng, input bit stc, input bit psc, input bit pzc,
                            input logic [NP-1:0] rs, input bit ms);
    int  init;
    bit  tick;
    init = ms ? TB : TA;
    if (ng) begin
      foreach (m_t[i]) m_t[i] = init;
      m_act = 0; m_state = 0; m_pre = 0; m_to = 0; m_los = 0;
      return;
    end
    case (m_state)
      0: begin
        foreach (m_t[i]) m_t[i] = init;
        if (stc) begin m_state = 1; m_pre = 0; m_act = 0; end
      end
      1: begin
        tick = (m_pre == TDIV - 1);
        if (rs != 0) begin
          for (int i = NP - 1; i >= 0; i--) if (rs[i]) m_los = i;
          m_state = 3;
        end else if (tick && m_t[m_act] == 1) begin
          m_t[m_act] = 0; m_state = 3; m_to = m_to | (1 << m_act); m_los = m_act;
        end else begin
          m_pre = tick ? 0 : m_pre + 1;
          if (tick && m_t[m_act] > 0) m_t[m_act] = m_t[m_act] - 1;
          if (psc) begin
            m_t[m_act] = (m_t[m_act] + INC > TMAX) ? TMAX : m_t[m_act] + INC;
            m_act = (m_act + 1) % NP;
            m_pre = 0;
          end else if (pzc) begin
            m_state = 2;
          end
        end
      end
      2: begin
        if (rs != 0) begin
          for (int i = NP - 1; i >= 0; i--) if (rs[i]) m_los = i;
          m_state = 3;
        end else if (pzc) begin
          m_state = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s.time%0d", tag, i), bus.times[i*TW +: TW], m_t[i]);
      chk($sformatf("%s.warn%0d", tag, i), bus.warn[i], (m_t[i] >= 1 && m_t[i] <= WTH) ? 1 : 0);
    end
    chk({tag, ".active"}, bus.active, m_act);
    chk({tag, ".state"}, bus.state, m_state);
    chk({tag, ".timeout"}, bus.timeout, m_to);
    chk({tag, ".game_over"}, bus.game_over, (m_state == 3) ? 1 : 0);
    chk({tag, ".loser"}, bus.loser, m_los);
  endtask

  // One clock: apply commands, advance the model at the edge, compare just after it
  task automatic cycle(input string tag, input bit ng, input bit stc, input bit psc,
                       input bit pzc, input logic [NP-1:0] rs);
    bus.new_game = ng; bus.start = stc; bus.pass = psc; bus.pause = pzc; bus.resign = rs;
    @(posedge clk);
    model_step(ng, stc, psc, pzc, rs, bus.mode_sel);
    #1;
    check_all(tag);
    bus.new_game = 0; bus.start = 0; bus.pass = 0; bus.pause = 0; bus.resign = '0;
    sbus.start = 0; sbus.pass = 0;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int k = 0; k < n; k++) cycle(tag, 0, 0, 0, 0, '0);
  endtask

  initial begin
    int guard;
    int r;
    bus.mode_sel = 1; bus.new_game = 0; bus.start = 0; bus.pass = 0; bus.pause = 0;
    bus.resign = '0;
    sbus.mode_sel = 0; sbus.new_game = 0; sbus.start = 0; sbus.pass = 0; sbus.pause = 0;
    sbus.resign = '0;

    // Reset state
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    clr = 1'b1;

    // 1: mode B load in IDLE, then 40 clocks of running = 10 ticks
    cycle("idle_load", 0, 0, 0, 0, '0);
    chk("idle_time_b", bus.times[0 +: TW], 300);
    cycle("start", 0, 1, 0, 0, '0);
    idle_cycles("run40", 40);
    chk("run40_t0", bus.times[0 +: TW], 290);
    chk("run40_t1", bus.times[TW +: TW], 300);

    // 2: passing with increment and wrap of the active index
    cycle("pass1", 0, 0, 1, 0, '0);
    chk("pass1_t0", bus.times[0 +: TW], 295);
    chk("pass1_act", bus.active, 1);
    cycle("pass2", 0, 0, 1, 0, '0);
    cycle("pass3", 0, 0, 1, 0, '0);
    chk("wrap_act", bus.active, 0);
    chk("pass3_t2", bus.times[2*TW +: TW], 305);

    // 3: pause holds everything, pass ignored, resume keeps prescaler phase
    cycle("pause", 0, 0, 0, 1, '0);
    idle_cycles("paused", 100);
    chk("paused_state", bus.state, 2);
    chk("paused_t0", bus.times[0 +: TW], 295);
    cycle("pass_in_pause", 0, 0, 1, 0, '0);
    chk("pause_pass_act", bus.active, 0);
    cycle("resume", 0, 0, 0, 1, '0);
    idle_cycles("resume_run", 2);
    chk("phase_hold_t0", bus.times[0 +: TW], 295);
    cycle("resume_tick", 0, 0, 0, 0, '0);
    chk("phase_tick_t0", bus.times[0 +: TW], 294);

    // 4: mode A, run player 0 down to 1, pass on the final tick
    bus.mode_sel = 0;
    cycle("newgame_a", 1, 0, 0, 0, '0);
    cycle("start_a", 0, 1, 0, 0, '0);
    guard = 0;
    while (!(m_t[0] == 1 && m_pre == TDIV - 1) && guard < 2000) begin
      cycle("countdown", 0, 0, 0, 0, '0);
      if (m_t[0] == 51) chk("warn_at_51", bus.warn[0], 0);
      if (m_t[0] == 50) chk("warn_at_50", bus.warn[0], 1);
      guard++;
    end
    chk("countdown_reach_1", bus.times[0 +: TW], 1);
    chk("warn_at_1", bus.warn[0], 1);
    cycle("flag_with_pass", 0, 0, 1, 0, '0);
    chk("flag_state", bus.state, 3);
    chk("flag_timeout", bus.timeout, 1);
    chk("flag_loser", bus.loser, 0);
    chk("flag_active", bus.active, 0);
    chk("flag_t0", bus.times[0 +: TW], 0);
    chk("warn_at_0", bus.warn[0], 0);
    idle_cycles("over_frozen", 10);
    chk("over_frozen_t0", bus.times[0 +: TW], 0);

    // 5: multi-bit resign, then new game
    cycle("newgame5", 1, 0, 0, 0, '0);
    cycle("start5", 0, 1, 0, 0, '0);
    idle_cycles("run5", 9);
    cycle("resign110", 0, 0, 0, 0, 3'b110);
    chk("resign_state", bus.state, 3);
    chk("resign_loser", bus.loser, 1);
    chk("resign_timeout", bus.timeout, 0);
    cycle("newgame_after", 1, 0, 0, 0, '0);
    chk("ng_state", bus.state, 0);
    chk("ng_t2", bus.times[2*TW +: TW], 100);

    // 6: increment saturates at the counter ceiling
    sbus.start = 1;
    cycle("sat_start", 0, 0, 0, 0, '0);
    chk("sat_init", sbus.times[0 +: TW], TMAX);
    sbus.pass = 1;
    cycle("sat_pass", 0, 0, 0, 0, '0);
    chk("sat_t0", sbus.times[0 +: TW], TMAX);
    chk("sat_act", sbus.active, 1);

    // Randomized play against the model
    for (int k = 0; k < 3000; k++) begin
      bit ng, stc, psc, pzc;
      logic [NP-1:0] rs;
      r   = $urandom_range(0, 99);
      ng  = (r < 2) || (m_state == 3 && $urandom_range(0, 19) == 0);
      stc = ($urandom_range(0, 9) == 0);
      psc = ($urandom_range(0, 11) == 0);
      pzc = ($urandom_range(0, 24) == 0);
      rs  = ($urandom_range(0, 199) == 0) ? NP'($urandom_range(1, 7)) : '0;
      if (m_state == 0 && $urandom_range(0, 7) == 0) bus.mode_sel = ~bus.mode_sel;
      cycle("rand", ng, stc, psc, pzc, rs);
    end

    // Asynchronous reset in the middle of a game
    cycle("pre_rst_ng", 1, 0, 0, 0, '0);
    cycle("pre_rst_start", 0, 1, 0, 0, '0);
    idle_cycles("pre_rst_run", 13);
    #2;
    clr = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    clr = 1'b1;
    cycle("post_rst", 0, 0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_timer_core.md
Name: game_timer_core

Overview:
- Parametrised N-player game clock core; successor to the fixed two-player countdown.
- Holds one countdown per player in tenths of a second and decrements only the active player's counter on an internal 0.1 s prescaler.
- Adds turn passing with Fischer increment, pause/resume, per-player resign, timeout detection and a game-over state.
- Sits between the debounced keypad decoder and the display/LED/buzzer drivers; consumes single-cycle command pulses and exposes registered times and status.

Parameters:
- NUM_PLAYERS, 2, number of players (2..8); AW = clog2(NUM_PLAYERS), minimum 1.
- TIME_W, 10, width of each player time counter, in tenths of a second.
- TICK_DIV, 5000000, clk cycles per 0.1 s tick (50 MHz board clock).
- INIT_TIME_A, 100, load value when mode_sel=0.
- INIT_TIME_B, 300, load value when mode_sel=1.
- INC_TIME, 0, tenths added to the outgoing player on pass.
- WARN_THRESH, 50, low-time warning threshold.

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous active-low reset.
- mode_sel  in  1  initial-time select; sampled only in IDLE.
- new_game  in  1  pulse; reload times and go to IDLE.
- start  in  1  pulse; IDLE->RUN.
- pass  in  1  pulse; active player ends turn.
- pause  in  1  pulse; toggles RUN<->PAUSE.
- resign  in  NUM_PLAYERS  per-player resign pulse.
- times  out  NUM_PLAYERS*TIME_W  player i at bits [i*TIME_W +: TIME_W].
- active  out  AW  index of the player whose clock runs.
- state  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=OVER.
- warn  out  NUM_PLAYERS  bit i = (1 <= time_i <= WARN_THRESH).
- timeout  out  NUM_PLAYERS  bit i set when player i flagged.
- game_over  out  1  state==OVER.
- loser  out  AW  valid when game_over.

Behaviour:
- Reset (clr=0, async): state=IDLE, all times=INIT_TIME_A, active=0, prescaler=0, timeout=0, loser=0, game_over=0.
- All outputs are registered except warn, which is decoded combinationally from the registered times.
- Command-to-output latency is 1 clk.
- new_game has the highest priority in every state. Next cycle: state=IDLE, times reload, active=0, timeout=0, loser=0, prescaler=0.
- IDLE:
  - Every cycle all times = mode_sel ? INIT_TIME_B : INIT_TIME_A.
  - start -> RUN, prescaler=0, active=0.
  - pass, pause and resign are ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; tick = (prescaler==TICK_DIV-1).
  - On tick, times[active] decrements if nonzero.
  - Per-cycle priority: resign > tick-to-zero > pass > pause.
  - resign (any bit) -> OVER, loser = lowest set index.
  - Tick taking times[active] from 1 to 0 -> OVER, timeout[active]=1, loser=active; a same-cycle pass is ignored.
  - pass: outgoing player gets (after any same-cycle decrement) + INC_TIME, saturating at 2^TIME_W-1. Then active = (active+1) mod NUM_PLAYERS and prescaler=0.
  - pause (no pass) -> PAUSE; prescaler value is held.
- PAUSE:
  - No decrement; prescaler frozen.
  - pause -> RUN, resuming from the held prescaler value.
  - resign -> OVER as in RUN.
  - pass and start are ignored.
- OVER:
  - Times, active, loser and timeout are frozen.
  - Only new_game leaves OVER.
- A zero time is never decremented below 0.
- A player whose time is 0 never becomes active in RUN, because reaching 0 forces OVER.
- Multiple simultaneous resign bits: lowest index loses; timeout stays 0.
- Reset asserted mid-game returns to the reset state immediately, regardless of clk.

Test Plan (TICK_DIV=4, NUM_PLAYERS=3, INC_TIME=5, TIME_W=10):
1. Reset, mode_sel=1 in IDLE -> all times=300, state=0. Pulse start, wait 40 clk -> times=290,300,300, active=0.
2. In RUN pulse pass -> next cycle times[0]=295, active=1. Pass twice more -> active wraps 2->0 and each outgoing player gains 5.
3. Pulse pause, wait 100 clk -> times unchanged, state=2. Pulse pause -> ticks resume at the held prescaler phase. Pass in PAUSE -> ignored.
4. mode_sel=0, set player 0 to 1 via countdown, pass coincident with the final tick -> state=3, timeout=3'b001, loser=0, no increment, active=0.
5. resign=3'b110 in RUN -> state=3, loser=1, timeout=0. Then new_game -> state=0, times reload, timeout=0.
6. Time 1023 with INC_TIME=5 on pass -> saturates at 1023. warn bit goes high at 50, stays high at 1, and is low at 0 and at 51.
